rs_encoder_seq: RTL and testbench
=================================

Name: rs_encoder_seq

Overview:
- Sequential systematic RS(15,9) encoder over GF(2^4), primitive polynomial x^4+x+1, t=3. It is the transmit-side counterpart of the team's RS(15,9) decoder.
- Takes a 36-bit message (9 symbols) and produces a 60-bit codeword (15 symbols) whose syndromes S1..S6, evaluated at alpha^1..alpha^6, are all zero.
- Uses a 6-stage GF(16) LFSR that absorbs one message symbol per clock, with a start/busy/valid handshake.

Parameters:
- None. Field, polynomial, n=15 and k=9 are fixed by the decoder. Internal localparams only.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- messageIn  input  36  message; symbol k = bits [4k+3:4k], k=0..8.
- encodeMessage  input  1  start request, sampled on the rising edge.
- codeWordOut  output  60  codeword; symbol j = bits [4j+3:4j], coefficient of x^j.
- codeWordValid  output  1  one-cycle pulse when codeWordOut is updated.
- encoderBusy  output  1  high while an encode is in progress.

Behaviour:
- Codeword layout:
  - c(x) = m(x)*x^6 + (m(x)*x^6 mod g(x)).
  - Message symbol k goes to codeword position k+6, so codeWordOut[59:24] = latched messageIn.
  - Parity occupies positions 0..5.
- Generator polynomial: g(x) = prod_{i=1..6}(x + alpha^i) = x^6 + 7x^5 + 9x^4 + 3x^3 + 12x^2 + 10x + 12 (coefficients in hex symbol form, alpha = 4'b0010).
- GF multiply: constant-coefficient GF(16) multipliers reduced modulo x^4+x+1. Addition is 4-bit XOR. No integer arithmetic on symbols.
- LFSR (registers r0..r5), per shift cycle:
  - fb = sym ^ r5
  - r5 = r4 ^ fb*7; r4 = r3 ^ fb*9; r3 = r2 ^ fb*3; r2 = r1 ^ fb*12; r1 = r0 ^ fb*10; r0 = fb*12
  - Symbols are fed highest degree first: message symbol 8, then 7, down to 0.
  - After 9 shifts, r_i is the parity coefficient of x^i.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: encodeMessage=1 → latch messageIn, clear r0..r5, clear the 4-bit symbol counter, go to SHIFT, encoderBusy=1 from the next cycle.
  - SHIFT: one symbol per cycle, indexed by the counter (8-cnt). When cnt=8, perform the final shift and go to DONE.
  - DONE: register codeWordOut = {latched msg, r5..r0}, codeWordValid=1 for exactly this cycle, encoderBusy=0, go to IDLE.
- Latency:
  - Start sampled at edge E0; codeWordOut/codeWordValid visible after edge E10.
  - encoderBusy is high for 9 cycles (after E1..E9).
- Back-to-back: encodeMessage is also accepted in DONE (the next encode starts immediately); max throughput is one codeword per 10 cycles.
- encodeMessage while busy (SHIFT): ignored, with no latch and no queue. messageIn changes during SHIFT have no effect.
- codeWordOut holds its last value between completions. It is updated only in DONE.
- Reset (any state, including mid-SHIFT):
  - State returns to IDLE; codeWordOut=0, codeWordValid=0, encoderBusy=0.
  - r0..r5, counter and message latch are cleared.
  - A partial encode is discarded and no valid pulse is emitted.
  - reset has priority over encodeMessage in the same cycle.
- Zero message: produces the all-zero codeword, which is a valid codeword.

Test Plan:
- Reset, then messageIn=36'h0, pulse start → after 10 edges codeWordValid=1 for one cycle, codeWordOut=60'h0; encoderBusy high exactly 9 cycles.
- messageIn=36'h000000001 (symbol 0 = 1) → codeWordOut=60'h000000001793CAC (parity symbols 0..5 = C,A,C,3,9,7, equal to g's low coefficients).
- 1000 random messages → for each, codeWordOut[59:24]=messageIn and golden-model syndromes S1..S6 (sum c_j*alpha^(i*j)) are all 0. Also loop back through the decoder with 0..3 random symbol errors injected → recovered message equals messageIn.
- Start pulsed at cycles 3 and 5 of SHIFT with different messageIn → ignored, output matches the first message. Start asserted in the DONE cycle → second codeword valid 10 cycles after that DONE.
- reset asserted at SHIFT cycle 4 together with encodeMessage=1 → no valid pulse; outputs 0 next cycle; FSM in IDLE. A new start afterwards produces the correct codeword.

Source files
------------

// File: rtl/rs_encoder_seq_if.sv
// Handshake/data bundle between an RS(15,9) encoder and its user.
// The master drives the message and start strobe; the slave returns the codeword.
interface rs_encoder_seq_if;
    logic [35:0] messageIn;
    logic        encodeMessage;
    logic [59:0] codeWordOut;
    logic        codeWordValid;
    logic        encoderBusy;

    modport master (
        output messageIn,
        output encodeMessage,
        input  codeWordOut,
        input  codeWordValid,
        input  encoderBusy
    );

    modport slave (
        input  messageIn,
        input  encodeMessage,
        output codeWordOut,
        output codeWordValid,
        output encoderBusy
    );
endinterface

// File: rtl/rs_encoder_seq.sv
// Sequential systematic RS(15,9) encoder over GF(16), x^4+x+1.
// A 6-stage LFSR absorbs one message symbol per clock, highest degree first.
module rs_encoder_seq (
    input  logic              clk,
    input  logic              reset,
    rs_encoder_seq_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    // Generator coefficients g0..g5 (g6 = 1), alpha = 4'b0010.
    localparam logic [3:0] G0 = 4'hC;
    localparam logic [3:0] G1 = 4'hA;
    localparam logic [3:0] G2 = 4'hC;
    localparam logic [3:0] G3 = 4'h3;
    localparam logic [3:0] G4 = 4'h9;
    localparam logic [3:0] G5 = 4'h7;
    localparam logic [3:0] LAST_CNT = 4'd8;

    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] aa;
        p  = '0;
        aa = a;
        for (int unsigned i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[2:0], 1'b0} ^ {2'b00, aa[3], aa[3]};
        end
        return p;
    endfunction

    state_t           state_q, state_d;
    logic [35:0]      msg_q, msg_d;
    logic [5:0][3:0]  r_q, r_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [59:0]      cw_q, cw_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;

    logic [3:0]       sym_idx;
    logic [5:0]       sym_base;
    logic [3:0]       sym;
    logic [3:0]       fb;
    logic [5:0][3:0]  r_shift;

    always_comb begin
        sym_idx  = LAST_CNT - cnt_q;
        sym_base = {sym_idx, 2'b00};
        sym      = msg_q[sym_base +: 4];
        fb       = sym ^ r_q[5];
        r_shift[5] = r_q[4] ^ gf_mul(fb, G5);
        r_shift[4] = r_q[3] ^ gf_mul(fb, G4);
        r_shift[3] = r_q[2] ^ gf_mul(fb, G3);
        r_shift[2] = r_q[1] ^ gf_mul(fb, G2);
        r_shift[1] = r_q[0] ^ gf_mul(fb, G1);
        r_shift[0] = gf_mul(fb, G0);
    end

    always_comb begin
        state_d = state_q;
        msg_d   = msg_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        cw_d    = cw_q;
        valid_d = 1'b0;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (bus.encodeMessage) begin
                    msg_d   = bus.messageIn;
                    r_d     = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                r_d    = r_shift;
                busy_d = 1'b1;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == LAST_CNT) state_d = DONE;
            end
            DONE: begin
                // Packed r_q flattens to {r5,...,r0}, i.e. parity in positions 5..0.
                cw_d    = {msg_q, r_q};
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
                if (bus.encodeMessage) begin
                    msg_d   = bus.messageIn;
                    r_d     = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            msg_q   <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            cw_q    <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            cw_q    <= cw_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.codeWordOut   = cw_q;
    assign bus.codeWordValid = valid_q;
    assign bus.encoderBusy   = busy_q;
endmodule

// File: tb/tb_rs_encoder_seq.sv
// Scoreboard bench for rs_encoder_seq: expected codewords come from polynomial
// long division over GF(16) using log/antilog tables; a monitor pops and compares.
module tb_rs_encoder_seq;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rs_encoder_seq_if bus_if ();

    rs_encoder_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int unsigned alog [15];
    int unsigned lg   [16];
    logic [3:0]  gpoly [7];
    logic [59:0] exp_q [$];
    logic [59:0] last_exp = '0;
    int          errors = 0;
    int          checks = 0;
    bit          prev_valid = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [3:0] fmul(input logic [3:0] a, input logic [3:0] b);
        if (a == 4'd0 || b == 4'd0) return 4'd0;
        return 4'(alog[(lg[a] + lg[b]) % 15]);
    endfunction

    task automatic build_tables();
        int unsigned a;
        a = 1;
        for (int e = 0; e < 15; e++) begin
            alog[e] = a;
            lg[a]   = e;
            a = a << 1;
            if ((a & 16) != 0) a = a ^ 19;
        end
        lg[0] = 0;
        for (int k = 0; k < 7; k++) gpoly[k] = 4'd0;
        gpoly[0] = 4'd1;
        for (int i = 1; i <= 6; i++) begin
            for (int k = i; k >= 1; k--)
                gpoly[k] = gpoly[k-1] ^ fmul(4'(alog[i]), gpoly[k]);
            gpoly[0] = fmul(4'(alog[i]), gpoly[0]);
        end
    endtask

    function automatic logic [59:0] ref_codeword(input logic [35:0] m);
        logic [3:0]  p [15];
        logic [3:0]  coef;
        logic [59:0] cw;
        for (int j = 0; j < 15; j++) p[j] = 4'd0;
        for (int k = 0; k < 9; k++) p[k+6] = m[4*k +: 4];
        for (int d = 14; d >= 6; d--) begin
            coef = p[d];
            for (int i = 0; i <= 6; i++) p[d-6+i] = p[d-6+i] ^ fmul(coef, gpoly[i]);
        end
        cw = '0;
        for (int j = 0; j < 6; j++) cw[4*j +: 4] = p[j];
        cw[59:24] = m;
        return cw;
    endfunction

    function automatic logic [3:0] syndrome_or(input logic [59:0] cw);
        logic [3:0] acc;
        logic [3:0] s;
        acc = 4'd0;
        for (int i = 1; i <= 6; i++) begin
            s = 4'd0;
            for (int j = 0; j < 15; j++) s = s ^ fmul(cw[4*j +: 4], 4'(alog[(i*j) % 15]));
            acc = acc | s;
        end
        return acc;
    endfunction

    function automatic logic [35:0] rand_msg();
        return 36'({$urandom, $urandom});
    endfunction

    always @(negedge clk) begin
        if (bus_if.codeWordValid) begin
            chk("valid_width", 64'(prev_valid), 64'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got codeword %h with no encode pending", bus_if.codeWordOut);
            end else begin
                chk("codeword", 64'(bus_if.codeWordOut), 64'(exp_q.pop_front()));
                chk("syndromes", 64'(syndrome_or(bus_if.codeWordOut)), 64'd0);
            end
        end
        prev_valid = bus_if.codeWordValid;
    end

    task automatic start(input logic [35:0] m);
        bus_if.messageIn     = m;
        bus_if.encodeMessage = 1'b1;
        exp_q.push_back(ref_codeword(m));
        last_exp = ref_codeword(m);
        @(negedge clk);
        bus_if.encodeMessage = 1'b0;
        bus_if.messageIn     = rand_msg();
    endtask

    task automatic wait_done(input bit disturb, input int rst_at);
        int lat;
        int bc;
        int vcount;
        lat = -1;
        bc = 0;
        vcount = 0;
        for (int k = 0; k <= 30; k++) begin
            if (k > 0 && bus_if.codeWordValid) begin
                lat = k;
                break;
            end
            if (bus_if.encoderBusy) bc++;
            if (k == rst_at) begin
                reset = 1'b1;
                bus_if.encodeMessage = 1'b1;
                void'(exp_q.pop_back());
                @(negedge clk);
                reset = 1'b0;
                bus_if.encodeMessage = 1'b0;
                last_exp = '0;
                chk("rst_cw", 64'(bus_if.codeWordOut), 64'd0);
                chk("rst_valid", 64'(bus_if.codeWordValid), 64'd0);
                chk("rst_busy", 64'(bus_if.encoderBusy), 64'd0);
                repeat (12) begin
                    @(negedge clk);
                    if (bus_if.codeWordValid || bus_if.encoderBusy) vcount++;
                end
                chk("rst_quiet", 64'(vcount), 64'd0);
                return;
            end
            bus_if.encodeMessage = disturb && (k == 3 || k == 5);
            if (disturb && (k == 3 || k == 5)) bus_if.messageIn = rand_msg();
            @(negedge clk);
        end
        chk("latency", 64'(lat), 64'd10);
        chk("busy_cycles", 64'(bc), 64'd9);
    endtask

    initial begin
        build_tables();
        bus_if.messageIn     = '0;
        bus_if.encodeMessage = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_cw", 64'(bus_if.codeWordOut), 64'd0);
        chk("reset_valid", 64'(bus_if.codeWordValid), 64'd0);
        chk("reset_busy", 64'(bus_if.encoderBusy), 64'd0);

        start(36'h0);
        wait_done(1'b0, -1);
        chk("zero_cw", 64'(bus_if.codeWordOut), 64'd0);

        start(36'h000000001);
        wait_done(1'b0, -1);
        chk("unit_cw", 64'(bus_if.codeWordOut), 64'h000000001793CAC);

        // Starts during SHIFT must be ignored.
        start(rand_msg());
        wait_done(1'b1, -1);
        repeat (3) @(negedge clk);
        chk("hold_cw", 64'(bus_if.codeWordOut), 64'(last_exp));

        // Start accepted in the DONE cycle.
        start(rand_msg());
        repeat (9) @(negedge clk);
        start(rand_msg());
        chk("b2b_first_valid", 64'(bus_if.codeWordValid), 64'd1);
        wait_done(1'b0, -1);

        // Reset with a concurrent start, mid-SHIFT.
        start(rand_msg());
        wait_done(1'b0, 4);
        start(rand_msg());
        wait_done(1'b0, -1);

        for (int n = 0; n < 1000; n++) begin
            start(rand_msg());
            wait_done(1'b0, -1);
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
